// File: rtl/token_ctrl_pkg.sv
// token_ctrl_pkg: state encoding and width helper shared by the token data controller.
package token_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, AUTH, DATA, LOCK} state_t;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/token_ctrl_regfile.sv
// token_ctrl_regfile: NUM_CH x DATA_W channel registers, one write port, combinational read of the addressed entry.
module token_ctrl_regfile #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [CH_W-1:0]   addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] regs [NUM_CH];

    assign rdata = regs[addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
        end else if (we) begin
            regs[addr] <= wdata;
        end
    end
endmodule

// File: rtl/token_data_controller.sv
// token_data_controller: token-gated write access to NUM_CH time-data registers with retry lockout and idle timeout.
module token_data_controller
    import token_ctrl_pkg::*;
#(
    parameter int TOKEN_W     = 3,
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 32,
    localparam int CH_W       = width_of(NUM_CH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [TOKEN_W-1:0] system_token,
    input  logic               request,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic               confirm,
    input  logic [TOKEN_W-1:0] user_token,
    input  logic               data_valid,
    input  logic [DATA_W-1:0]  TimeData,
    output logic [DATA_W-1:0]  data_P,
    output logic [DATA_W-1:0]  data_Q,
    output logic               granted,
    output logic               locked,
    output logic               done,
    output logic               error
);
    // One timer serves the idle timeout and the lockout window.
    localparam int TW = width_of(TIMEOUT > LOCK_CYCLES ? TIMEOUT : LOCK_CYCLES);
    localparam int FW = width_of(MAX_TRIES + 1);

    state_t            state;
    logic [CH_W-1:0]   ch_q;
    logic [TW-1:0]     timer;
    logic [FW-1:0]     fail_cnt;
    logic [DATA_W-1:0] rd;
    logic              we;
    logic              timeout_hit;
    logic              lock_end;
    logic              match;

    assign granted     = state == DATA;
    assign locked      = state == LOCK;
    assign match       = user_token == system_token;
    assign timeout_hit = timer == TW'(TIMEOUT - 1);
    assign lock_end    = timer == TW'(LOCK_CYCLES - 1);
    assign we          = (state == DATA) && request && data_valid;

    token_ctrl_regfile #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .addr  (ch_q),
        .wdata (TimeData),
        .rdata (rd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ch_q     <= '0;
            timer    <= '0;
            fail_cnt <= '0;
            data_P   <= '0;
            data_Q   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (request) begin
                    if (32'(ch_sel) >= NUM_CH) begin
                        error <= 1'b1;
                    end else begin
                        ch_q     <= ch_sel;
                        timer    <= '0;
                        fail_cnt <= '0;
                        state    <= AUTH;
                    end
                end
                AUTH: if (!request) begin
                    state <= IDLE;
                    error <= 1'b1;
                end else if (confirm && match) begin
                    state <= DATA;
                    timer <= '0;
                end else if (confirm) begin
                    fail_cnt <= fail_cnt + 1'b1;
                    timer    <= '0;
                    if (fail_cnt + 1'b1 == FW'(MAX_TRIES)) begin
                        state <= LOCK;
                        error <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    state <= IDLE;
                    error <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                DATA: if (!request) begin
                    state <= IDLE;
                    error <= 1'b1;
                end else if (data_valid) begin
                    data_Q <= rd;
                    data_P <= TimeData;
                    done   <= 1'b1;
                    state  <= IDLE;
                end else if (timeout_hit) begin
                    state <= IDLE;
                    error <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                LOCK: if (lock_end) begin
                    state    <= IDLE;
                    fail_cnt <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_token_data_controller.sv
// tb_token_data_controller: directed stimulus, per-cycle comparison against a session-level model, plus literal checks.
module tb_token_data_controller;
    localparam int NUM_CH = 4, MAX_TRIES = 3, LOCK_CYCLES = 16, TIMEOUT = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] system_token = 3'b101;
    logic       request = 1'b0;
    logic [1:0] ch_sel = '0;
    logic       confirm = 1'b0;
    logic [2:0] user_token = '0;
    logic       data_valid = 1'b0;
    logic [7:0] TimeData = '0;
    logic [7:0] data_P, data_Q;
    logic       granted, locked, done, error;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    token_data_controller dut (
        .clock(clock), .reset(reset), .system_token(system_token), .request(request),
        .ch_sel(ch_sel), .confirm(confirm), .user_token(user_token), .data_valid(data_valid),
        .TimeData(TimeData), .data_P(data_P), .data_Q(data_Q), .granted(granted),
        .locked(locked), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Session-level model: phase name, idle cycles elapsed, tries remaining, lock cycles remaining.
    localparam int M_IDLE = 0, M_AUTH = 1, M_DATA = 2, M_LOCK = 3;
    int         mode = M_IDLE;
    int         idle_run = 0;
    int         tries_left = 0;
    int         lock_left = 0;
    int         ch = 0;
    logic [7:0] mem [NUM_CH];
    logic [7:0] e_P, e_Q;
    logic       e_done, e_error;

    always @(posedge clock) begin
        cycle <= cycle + 1;
        e_done <= 1'b0;
        e_error <= 1'b0;
        if (reset) begin
            mode <= M_IDLE;
            idle_run <= 0;
            tries_left <= 0;
            lock_left <= 0;
            e_P <= '0;
            e_Q <= '0;
            for (int i = 0; i < NUM_CH; i++) mem[i] <= '0;
        end else if (mode == M_IDLE) begin
            if (request && int'(ch_sel) >= NUM_CH) e_error <= 1'b1;
            else if (request) begin
                ch <= int'(ch_sel);
                idle_run <= 0;
                tries_left <= MAX_TRIES;
                mode <= M_AUTH;
            end
        end else if (mode == M_LOCK) begin
            if (lock_left == 1) mode <= M_IDLE;
            else lock_left <= lock_left - 1;
        end else if (!request) begin
            mode <= M_IDLE;
            e_error <= 1'b1;
        end else if (mode == M_AUTH && confirm && user_token == system_token) begin
            mode <= M_DATA;
            idle_run <= 0;
        end else if (mode == M_AUTH && confirm) begin
            tries_left <= tries_left - 1;
            idle_run <= 0;
            if (tries_left == 1) begin
                mode <= M_LOCK;
                lock_left <= LOCK_CYCLES;
                e_error <= 1'b1;
            end
        end else if (mode == M_DATA && data_valid) begin
            e_Q <= mem[ch];
            mem[ch] <= TimeData;
            e_P <= TimeData;
            e_done <= 1'b1;
            mode <= M_IDLE;
        end else if (idle_run + 1 == TIMEOUT) begin
            mode <= M_IDLE;
            e_error <= 1'b1;
        end else begin
            idle_run <= idle_run + 1;
        end
    end

    // Per-cycle compare on the falling edge, once reset has been seen by both sides.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            checks++;
            if ({granted, locked, done, error, data_P, data_Q} !==
                {mode == M_DATA, mode == M_LOCK, e_done, e_error, e_P, e_Q}) begin
                failures++;
                $display("FAIL cycle %0d outputs: got g=%b l=%b d=%b e=%b P=%h Q=%h want g=%b l=%b d=%b e=%b P=%h Q=%h",
                         cycle, granted, locked, done, error, data_P, data_Q,
                         mode == M_DATA, mode == M_LOCK, e_done, e_error, e_P, e_Q);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic session(input logic [1:0] c, input logic [7:0] d, input logic [7:0] q);
        request = 1'b1; ch_sel = c;
        step(1);
        confirm = 1'b1; user_token = 3'b101;
        step(1);
        confirm = 1'b0; data_valid = 1'b1; TimeData = d;
        check("grant", int'(granted), 1);
        step(1);
        data_valid = 1'b0; request = 1'b0;
        check("done", int'(done), 1);
        check("data_P", int'(data_P), int'(d));
        check("data_Q", int'(data_Q), int'(q));
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        step(2);
        check("reset_outputs", int'({granted, locked, done, error, data_P, data_Q}), 0);
        reset = 1'b0;
        step(1);

        session(2'd2, 8'hF2, 8'h00);
        session(2'd2, 8'h3C, 8'hF2);
        session(2'd0, 8'h55, 8'h00);

        // Two misses then a match stays below the lockout threshold.
        request = 1'b1; ch_sel = 2'd1;
        step(1);
        confirm = 1'b1; user_token = 3'b011;
        step(2);
        user_token = 3'b101;
        step(1);
        confirm = 1'b0;
        check("grant_after_two_miss", int'(granted), 1);
        request = 1'b0;
        step(1);
        check("abort_in_data", int'(error), 1);
        step(1);

        // Lockout: three misses, request held through the window.
        request = 1'b1; ch_sel = 2'd1;
        step(1);
        confirm = 1'b1; user_token = 3'b011;
        step(3);
        confirm = 1'b0;
        check("lock_error", int'(error), 1);
        n = 0;
        while (locked && n < 40) begin
            n++;
            step(1);
        end
        check("lock_len", n, 16);
        check("idle_after_lock", int'({granted, locked}), 0);
        step(1);
        confirm = 1'b1; user_token = 3'b101;
        step(1);
        confirm = 1'b0; data_valid = 1'b1; TimeData = 8'hA5;
        check("grant_after_lock", int'(granted), 1);
        step(1);
        data_valid = 1'b0; request = 1'b0;
        check("lock_write_Q", int'(data_Q), 0);
        step(1);

        // DATA timeout.
        request = 1'b1; ch_sel = 2'd3;
        step(1);
        confirm = 1'b1;
        step(1);
        confirm = 1'b0;
        step(31);
        check("data_before_timeout", int'({granted, error}), 2);
        step(1);
        check("data_timeout", int'({granted, error}), 1);
        request = 1'b0;
        step(1);

        // AUTH timeout.
        request = 1'b1; ch_sel = 2'd3;
        step(32);
        check("auth_before_timeout", int'(error), 0);
        step(1);
        check("auth_timeout", int'(error), 1);
        request = 1'b0;
        step(1);
        session(2'd3, 8'h77, 8'h00);

        // Request drop in AUTH, then in DATA with data_valid high.
        request = 1'b1; ch_sel = 2'd0;
        step(1);
        request = 1'b0;
        step(1);
        check("abort_auth", int'(error), 1);
        request = 1'b1;
        step(1);
        confirm = 1'b1;
        step(1);
        confirm = 1'b0; request = 1'b0; data_valid = 1'b1; TimeData = 8'hEE;
        step(1);
        data_valid = 1'b0;
        check("abort_data", int'({done, error}), 1);
        step(1);
        session(2'd0, 8'h66, 8'h55);

        // Reset during LOCK.
        request = 1'b1; ch_sel = 2'd1;
        step(1);
        confirm = 1'b1; user_token = 3'b000;
        step(3);
        confirm = 1'b0;
        step(4);
        reset = 1'b1; request = 1'b0;
        step(1);
        check("reset_in_lock", int'({locked, error}), 0);
        reset = 1'b0;
        step(1);

        // Reset during DATA with a concurrent data_valid.
        request = 1'b1; ch_sel = 2'd2;
        step(1);
        confirm = 1'b1; user_token = 3'b101;
        step(1);
        confirm = 1'b0; reset = 1'b1; data_valid = 1'b1; TimeData = 8'hEE;
        step(1);
        check("reset_in_data", int'({granted, done, data_P, data_Q}), 0);
        reset = 1'b0; data_valid = 1'b0; request = 1'b0;
        step(1);
        session(2'd2, 8'h11, 8'h00);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
